serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu_pkg.sv | 13 +
 rtl/serial_alu_digit.sv | 48 ++++
 rtl/serial_alu.sv | 122 ++++++++++++
 tb/tb_serial_alu.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the digit-serial ALU: op encodings and the control FSM state type.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/serial_alu_digit.sv
// One DIGIT-bit ALU slice, reused every RUN cycle. NOR decode exists only with SERIAL_ALU_NOR_EN.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [DIGIT-1:0] r,
    output logic             cout,
    output logic             ctop
);

    logic [DIGIT-1:0] bx;
    logic [DIGIT:0]   c;

    // Ripple chain; op[2] selects subtract (invert b, carry-in of 1 comes via cin).
    always_comb begin
        bx   = op[2] ? ~b : b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++)
            c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end

    // Illegal codes fall into the default arm: zero result, zero carries.
    always_comb begin
        r    = '0;
        cout = 1'b0;
        ctop = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
`ifdef SERIAL_ALU_NOR_EN
            OP_NOR: r = ~(a | b);
`endif
            OP_ADD, OP_SUB, OP_SLT: begin
                r    = a ^ bx ^ c[DIGIT-1:0];
                cout = c[DIGIT];
                ctop = c[DIGIT-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: WIDTH/DIGIT cycles per op, LSB digit first. Optional NOR via SERIAL_ALU_NOR_EN.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_alu: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [KW-1:0]    k;
    logic             carry;

    logic [DIGIT-1:0] d_r;
    logic             d_cout, d_ctop;

    serial_alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .op   (op_q),
        .cin  (carry),
        .r    (d_r),
        .cout (d_cout),
        .ctop (d_ctop)
    );

    // Result fills from the top and shifts right, so after N digits bit 0 is in place.
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       res_sh, res_fin;
    logic                   ovf_fin;

    always_comb begin
        cat     = {d_r, result};
        res_sh  = cat[WIDTH+DIGIT-1:DIGIT];
        ovf_fin = d_ctop ^ d_cout;
        res_fin = res_sh;
        if (op_q == OP_SLT) begin
            res_fin    = '0;
            res_fin[0] = d_r[DIGIT-1] ^ ovf_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            k         <= '0;
            carry     <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        k        <= '0;
                        carry    <= op[2];
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    carry <= d_cout;
                    k     <= k + KW'(1);
                    if (k == KW'(N - 1)) begin
                        result    <= res_fin;
                        cout      <= d_cout;
                        overflow  <= ovf_fin;
                        zero      <= (res_fin == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        result <= res_sh;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed-vector bench for serial_alu (WIDTH=32, DIGIT=4); NOR expectation follows SERIAL_ALU_NOR_EN.
module tb_serial_alu;
    import serial_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   op = 3'b000;
    logic         in_ready, out_valid, cout, overflow, zero;
    logic [W-1:0] result;

    int checks = 0, failures = 0;

    serial_alu #(.WIDTH(W), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         co, ov, z;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one op, return the number of edges from accept to out_valid (99 = timeout).
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output int lat);
        int g = 0;
        while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = 99;
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, ".released"}, {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int lat;
        logic [2:0] op100 = 3'b100;
        logic [W-1:0] nor_exp;
`ifdef SERIAL_ALU_NOR_EN
        nor_exp = 32'hF000_F000;
`else
        nor_exp = 32'h0;
`endif
        vecs[0]  = '{"add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0};
        vecs[1]  = '{"sub_eq",   OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1};
        vecs[2]  = '{"slt_neg",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0};
        vecs[3]  = '{"slt_ovf",  OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 1};
        vecs[4]  = '{"and",      OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0};
        vecs[5]  = '{"or",       OP_OR,  32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 0, 0, 0};
        vecs[6]  = '{"add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1};
        vecs[7]  = '{"sub_ovf",  OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0};
        vecs[8]  = '{"add_mid",  OP_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0};
        vecs[9]  = '{"ill_011",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1};
        vecs[10] = '{"ill_101",  3'b101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0, 1};
        vecs[11] = '{"op100",    op100,  32'h0F0F0F0F, 32'h00FF00FF, nor_exp, 0, 0, nor_exp == 0};
        vecs[12] = '{"sub_neg",  OP_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0};
        vecs[13] = '{"slt_lt",   OP_SLT, 32'h00000003, 32'h00000005, 32'h00000001, 0, 0, 0};
        vecs[14] = '{"and_zero", OP_AND, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 0, 0, 1};

        // Reset state
        #7;
        chk("rst.result", result, '0);
        chk("rst.flags", {28'b0, cout, overflow, zero, out_valid}, '0);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk({vecs[i].name, ".latency"}, lat, 32'd8);
            chk({vecs[i].name, ".result"}, result, vecs[i].res);
            chk({vecs[i].name, ".flags"}, {29'b0, cout, overflow, zero},
                {29'b0, vecs[i].co, vecs[i].ov, vecs[i].z});
            finish_op(vecs[i].name);
        end

        // Backpressure in DONE with a stray in_valid pulse
        start_op(OP_ADD, 32'h00000010, 32'h00000020, lat);
        chk("hold.latency", lat, 32'd8);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin op = OP_SUB; a = 32'hDEADBEEF; b = 32'h1; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("hold.result", result, 32'h00000030);
            chk("hold.hs", {30'b0, out_valid, in_ready}, {30'b0, 1'b1, 1'b0});
        end
        finish_op("hold");
        chk("hold.idle_stays", {31'b0, out_valid}, '0);

        // Reset mid-RUN at k=3, then a clean op
        op = OP_ADD; a = 32'h11111111; b = 32'h22222222; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.hs", {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
        chk("midrst.result", result, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        lat = 0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) lat++; end
        chk("midrst.no_out", lat, 0);
        start_op(OP_SUB, 32'h00000100, 32'h00000001, lat);
        chk("post.latency", lat, 32'd8);
        chk("post.result", result, 32'h000000FF);
        chk("post.flags", {29'b0, cout, overflow, zero}, {29'b0, 1'b1, 1'b0, 1'b0});
        finish_op("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
